mem_port_arbiter: RTL and testbench

Shares the single unified memory port between the pipeline's instruction-fetch stage and its memory (load/store) stage. Requests from both stages are sequenced onto one variable-latency req/ack bus. Data accesses win by default, with a bounded-starvation guarantee for fetch, a bus timeout, and per-stage stall outputs that freeze the fetch or memory stage until its access completes.

---
 rtl/mem_port_arbiter_pkg.sv | 20 ++
 rtl/mem_port_arbiter_if.sv | 45 ++++
 rtl/mem_arb_wait_timer.sv | 25 ++
 rtl/mem_port_arbiter.sv | 139 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 315 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the unified memory-port arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUS_IF = 2'd1,
        BUS_D  = 2'd2,
        RESP   = 2'd3
    } arb_state_e;

    localparam int         DEF_STARVE_LIMIT = 4;
    localparam int         DEF_TIMEOUT      = 16;
    localparam logic [3:0] FETCH_BE         = 4'b1111;

    // Streak counter width: at least 3 bits, wide enough to hold the limit.
    function automatic int streak_width(input int limit);
        return (limit < 8) ? 3 : $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Fetch, data and memory-bus signals of the shared memory port.
// slave: the arbiter. master: the pipeline stages and memory driving it.
interface mem_port_arbiter_if;
    logic        w_if_req;
    logic [31:0] w_if_addr_32;
    logic [31:0] w_if_rdata_32;
    logic        w_if_valid;
    logic        w_if_stall;

    logic        w_mem_req;
    logic        w_mem_write;
    logic [31:0] w_mem_addr_32;
    logic [31:0] w_mem_wdata_32;
    logic [3:0]  w_mem_be_4;
    logic [31:0] w_mem_rdata_32;
    logic        w_mem_done;
    logic        w_mem_stall;

    logic        w_bus_err;
    logic        w_bus_req;
    logic        w_bus_write;
    logic [31:0] w_bus_addr_32;
    logic [31:0] w_bus_wdata_32;
    logic [3:0]  w_bus_be_4;
    logic        w_bus_ack;
    logic [31:0] w_bus_rdata_32;

    modport slave (
        input  w_if_req, w_if_addr_32,
        input  w_mem_req, w_mem_write, w_mem_addr_32, w_mem_wdata_32, w_mem_be_4,
        input  w_bus_ack, w_bus_rdata_32,
        output w_if_rdata_32, w_if_valid, w_if_stall,
        output w_mem_rdata_32, w_mem_done, w_mem_stall,
        output w_bus_err, w_bus_req, w_bus_write, w_bus_addr_32, w_bus_wdata_32, w_bus_be_4
    );

    modport master (
        output w_if_req, w_if_addr_32,
        output w_mem_req, w_mem_write, w_mem_addr_32, w_mem_wdata_32, w_mem_be_4,
        output w_bus_ack, w_bus_rdata_32,
        input  w_if_rdata_32, w_if_valid, w_if_stall,
        input  w_mem_rdata_32, w_mem_done, w_mem_stall,
        input  w_bus_err, w_bus_req, w_bus_write, w_bus_addr_32, w_bus_wdata_32, w_bus_be_4
    );
endinterface

// File: rtl/mem_arb_wait_timer.sv
// Counts bus cycles spent waiting for ack; expired marks the last allowed cycle.
module mem_arb_wait_timer
    import mem_arb_pkg::*;
#(
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic clock,
    input  logic reset_n,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expired
);
    localparam int CW = $clog2(TIMEOUT);

    logic [CW-1:0] r_cnt;

    // Wait counter: clear wins over enable.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)   r_cnt <= '0;
        else if (i_clr) r_cnt <= '0;
        else if (i_en)  r_cnt <= r_cnt + CW'(1);
    end

    assign o_expired = (r_cnt == CW'(TIMEOUT - 1));
endmodule

// File: rtl/mem_port_arbiter.sv
// Sequences fetch and load/store accesses onto one req/ack memory bus.
// Data wins by default; fetch is forced through after STARVE_LIMIT data grants.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = DEF_STARVE_LIMIT,
    parameter int TIMEOUT      = DEF_TIMEOUT
) (
    input  logic               clock,
    input  logic               reset_n,
    mem_port_arbiter_if.slave  bus
);
    localparam int            SW    = streak_width(STARVE_LIMIT);
    localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

    arb_state_e    r_state;
    logic [SW-1:0] r_streak;
    logic          r_bus_req;
    logic          r_bus_write;
    logic [31:0]   r_bus_addr;
    logic [31:0]   r_bus_wdata;
    logic [3:0]    r_bus_be;
    logic [31:0]   r_if_rdata;
    logic          r_if_valid;
    logic [31:0]   r_mem_rdata;
    logic          r_mem_done;
    logic          r_bus_err;

    logic          w_on_bus;
    logic          w_tmr_clr;
    logic          w_tmr_en;
    logic          w_expired;
    logic          w_pick_if;

    assign w_on_bus  = (r_state == BUS_IF) || (r_state == BUS_D);
    assign w_tmr_clr = (r_state == RESP);
    assign w_tmr_en  = w_on_bus && !bus.w_bus_ack;
    // Fetch goes first when alone, or when it has waited out the data streak.
    assign w_pick_if = bus.w_if_req && (!bus.w_mem_req || (r_streak == LIMIT));

    mem_arb_wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clock     (clock),
        .reset_n   (reset_n),
        .i_clr     (w_tmr_clr),
        .i_en      (w_tmr_en),
        .o_expired (w_expired)
    );

    // Arbitration FSM with all bus and response outputs registered.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= IDLE;
            r_streak    <= '0;
            r_bus_req   <= 1'b0;
            r_bus_write <= 1'b0;
            r_bus_addr  <= '0;
            r_bus_wdata <= '0;
            r_bus_be    <= '0;
            r_if_rdata  <= '0;
            r_if_valid  <= 1'b0;
            r_mem_rdata <= '0;
            r_mem_done  <= 1'b0;
            r_bus_err   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.w_mem_req && !w_pick_if) begin
                        r_state     <= BUS_D;
                        r_bus_req   <= 1'b1;
                        r_bus_write <= bus.w_mem_write;
                        r_bus_addr  <= bus.w_mem_addr_32;
                        r_bus_wdata <= bus.w_mem_wdata_32;
                        r_bus_be    <= bus.w_mem_be_4;
                        if (bus.w_if_req && (r_streak != LIMIT))
                            r_streak <= r_streak + SW'(1);
                    end else if (w_pick_if) begin
                        r_state     <= BUS_IF;
                        r_bus_req   <= 1'b1;
                        r_bus_write <= 1'b0;
                        r_bus_addr  <= bus.w_if_addr_32;
                        r_bus_wdata <= '0;
                        r_bus_be    <= FETCH_BE;
                        r_streak    <= '0;
                    end
                end
                BUS_IF: begin
                    if (bus.w_bus_ack) begin
                        r_state    <= RESP;
                        r_bus_req  <= 1'b0;
                        r_if_rdata <= bus.w_bus_rdata_32;
                        r_if_valid <= 1'b1;
                    end else if (w_expired) begin
                        r_state    <= RESP;
                        r_bus_req  <= 1'b0;
                        r_if_rdata <= '0;
                        r_if_valid <= 1'b1;
                        r_bus_err  <= 1'b1;
                    end
                end
                BUS_D: begin
                    if (bus.w_bus_ack) begin
                        r_state    <= RESP;
                        r_bus_req  <= 1'b0;
                        r_mem_done <= 1'b1;
                        if (!r_bus_write)
                            r_mem_rdata <= bus.w_bus_rdata_32;
                    end else if (w_expired) begin
                        r_state     <= RESP;
                        r_bus_req   <= 1'b0;
                        r_mem_rdata <= '0;
                        r_mem_done  <= 1'b1;
                        r_bus_err   <= 1'b1;
                    end
                end
                RESP: begin
                    // Completion pulse lasts exactly this one cycle; no grant here.
                    r_state    <= IDLE;
                    r_if_valid <= 1'b0;
                    r_mem_done <= 1'b0;
                    r_bus_err  <= 1'b0;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.w_bus_req      = r_bus_req;
    assign bus.w_bus_write    = r_bus_write;
    assign bus.w_bus_addr_32  = r_bus_addr;
    assign bus.w_bus_wdata_32 = r_bus_wdata;
    assign bus.w_bus_be_4     = r_bus_be;
    assign bus.w_if_rdata_32  = r_if_rdata;
    assign bus.w_if_valid     = r_if_valid;
    assign bus.w_mem_rdata_32 = r_mem_rdata;
    assign bus.w_mem_done     = r_mem_done;
    assign bus.w_bus_err      = r_bus_err;
    assign bus.w_if_stall     = bus.w_if_req  & ~r_if_valid;
    assign bus.w_mem_stall    = bus.w_mem_req & ~r_mem_done;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: requests push expected responses,
// a monitor checks grants, bus timing and completions against a model.
module tb_mem_port_arbiter;
    localparam int SL = 4;
    localparam int TO = 16;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    mem_port_arbiter_if bus();

    mem_port_arbiter #(.STARVE_LIMIT(SL), .TIMEOUT(TO)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          w;
    } exp_t;

    exp_t        fq[$];
    exp_t        mq[$];
    logic [31:0] mem_last = '0;
    int          n_checks = 0;
    int          n_pass = 0;
    int          fixed_wait = 0;
    bit          f_busy = 0, m_busy = 0;
    int          f_pct = 0, m_pct = 0;
    string       glog = "";

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h want %h", name, act, exp);
    endtask

    task automatic chk_s(input string name, input string act, input string exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %s want %s", name, act, exp);
    endtask

    // Memory contents as seen by the bench: a fixed hash of the address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0000_0040) return 32'h2402_0005;
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
    endfunction

    // Wait states before ack, encoded in the address; 100 means never acked.
    function automatic int eff_wait(input logic [31:0] a);
        if (fixed_wait >= 0) return fixed_wait;
        case (a[27:24])
            4'hF:    return 100;
            4'hE:    return TO - 1;
            4'hD:    return TO - 2;
            4'hC:    return 5;
            default: return int'(a[25:24]);
        endcase
    endfunction

    function automatic int bus_cycles(input int w);
        return (w >= TO) ? TO : w + 1;
    endfunction

    task automatic issue_fetch(input logic [31:0] a);
        exp_t e;
        e.w     = eff_wait(a);
        e.err   = (e.w >= TO);
        e.rdata = e.err ? 32'h0 : mem_word(a);
        fq.push_back(e);
        bus.w_if_req     = 1'b1;
        bus.w_if_addr_32 = a;
        f_busy = 1;
    endtask

    task automatic issue_mem(input bit wr, input logic [31:0] a, input logic [31:0] wd,
                             input logic [3:0] be);
        exp_t e;
        e.w   = eff_wait(a);
        e.err = (e.w >= TO);
        if (e.err)   e.rdata = 32'h0;
        else if (wr) e.rdata = mem_last;
        else         e.rdata = mem_word(a);
        mem_last = e.rdata;
        mq.push_back(e);
        bus.w_mem_req      = 1'b1;
        bus.w_mem_write    = wr;
        bus.w_mem_addr_32  = a;
        bus.w_mem_wdata_32 = wd;
        bus.w_mem_be_4     = be;
        m_busy = 1;
    endtask

    // One cycle of requester behaviour: retire completions, maybe issue new work.
    task automatic step();
        @(negedge clock);
        if (f_busy && bus.w_if_valid)  begin f_busy = 0; bus.w_if_req  = 1'b0; end
        if (m_busy && bus.w_mem_done)  begin m_busy = 0; bus.w_mem_req = 1'b0; end
        if (!f_busy && int'($urandom_range(99)) < f_pct) issue_fetch($urandom);
        if (!m_busy && int'($urandom_range(99)) < m_pct)
            issue_mem(1'($urandom_range(1)), $urandom, $urandom, 4'($urandom));
    endtask

    task automatic wait_idle();
        int k = 0;
        while ((f_busy || m_busy) && k < 400) begin step(); k++; end
        chk("drain", 64'(f_busy || m_busy), 64'd0);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_bus_req"},   64'(bus.w_bus_req),      64'd0);
        chk({tag, "_bus_write"}, 64'(bus.w_bus_write),    64'd0);
        chk({tag, "_bus_addr"},  64'(bus.w_bus_addr_32),  64'd0);
        chk({tag, "_bus_wdata"}, 64'(bus.w_bus_wdata_32), 64'd0);
        chk({tag, "_bus_be"},    64'(bus.w_bus_be_4),     64'd0);
        chk({tag, "_if_valid"},  64'(bus.w_if_valid),     64'd0);
        chk({tag, "_if_rdata"},  64'(bus.w_if_rdata_32),  64'd0);
        chk({tag, "_mem_done"},  64'(bus.w_mem_done),     64'd0);
        chk({tag, "_mem_rdata"}, 64'(bus.w_mem_rdata_32), 64'd0);
        chk({tag, "_bus_err"},   64'(bus.w_bus_err),      64'd0);
        chk({tag, "_if_stall"},  64'(bus.w_if_stall),     64'd0);
        chk({tag, "_mem_stall"}, 64'(bus.w_mem_stall),    64'd0);
    endtask

    // Memory responder: acks after the address-encoded wait count, and sprinkles
    // stray acks while no request is on the bus.
    int bcnt = 0;
    initial begin
        bus.w_bus_ack      = 1'b0;
        bus.w_bus_rdata_32 = '0;
        forever begin
            @(negedge clock);
            if (bus.w_bus_req) begin
                bcnt++;
                if (bcnt - 1 == eff_wait(bus.w_bus_addr_32)) begin
                    bus.w_bus_ack      = 1'b1;
                    bus.w_bus_rdata_32 = mem_word(bus.w_bus_addr_32);
                end else begin
                    bus.w_bus_ack      = 1'b0;
                    bus.w_bus_rdata_32 = $urandom;
                end
            end else begin
                bcnt = 0;
                bus.w_bus_ack      = ($urandom_range(3) == 0);
                bus.w_bus_rdata_32 = $urandom;
            end
        end
    end

    // Monitor: grant choice, bus field stability/duration, completion scoreboard.
    bit          prev_req = 0;
    bit          stable;
    int          bcyc, exp_cyc;
    int          streak_m = 0;
    logic [31:0] cap_addr, cap_wdata;
    logic        cap_wr;
    logic [3:0]  cap_be;
    always @(posedge clock) begin
        #1;
        if (!reset_n) begin
            prev_req = 0;
            streak_m = 0;
        end else begin
            if (bus.w_bus_req && !prev_req) begin
                bit fr, mr, pick_f;
                fr = bus.w_if_req;
                mr = bus.w_mem_req;
                if (!fr && !mr) chk("spurious_grant", 64'd1, 64'd0);
                // Fetch gets the port if alone or after SL data grants made while it waited.
                pick_f = fr && (!mr || streak_m == SL);
                exp_cyc = 1;
                if (pick_f) begin
                    glog = {glog, "F"};
                    streak_m = 0;
                    chk("grant_addr", 64'(bus.w_bus_addr_32), 64'(bus.w_if_addr_32));
                    chk("grant_ctl", {bus.w_bus_write, bus.w_bus_be_4, bus.w_bus_wdata_32},
                        {1'b0, 4'hF, 32'h0});
                    chk("if_stall_wait", 64'(bus.w_if_stall), 64'd1);
                    if (fq.size() > 0) exp_cyc = bus_cycles(fq[0].w);
                    else chk("grant_no_fetch", 64'd1, 64'd0);
                end else begin
                    glog = {glog, "D"};
                    if (fr && streak_m < SL) streak_m++;
                    chk("grant_addr", 64'(bus.w_bus_addr_32), 64'(bus.w_mem_addr_32));
                    chk("grant_ctl", {bus.w_bus_write, bus.w_bus_be_4, bus.w_bus_wdata_32},
                        {bus.w_mem_write, bus.w_mem_be_4, bus.w_mem_wdata_32});
                    chk("mem_stall_wait", 64'(bus.w_mem_stall), 64'd1);
                    if (mq.size() > 0) exp_cyc = bus_cycles(mq[0].w);
                    else chk("grant_no_data", 64'd1, 64'd0);
                end
                cap_addr  = bus.w_bus_addr_32;
                cap_wdata = bus.w_bus_wdata_32;
                cap_wr    = bus.w_bus_write;
                cap_be    = bus.w_bus_be_4;
                bcyc      = 1;
                stable    = 1;
            end else if (bus.w_bus_req) begin
                bcyc++;
                if (bus.w_bus_addr_32 !== cap_addr || bus.w_bus_wdata_32 !== cap_wdata ||
                    bus.w_bus_write !== cap_wr || bus.w_bus_be_4 !== cap_be) stable = 0;
            end else if (prev_req) begin
                chk("bus_cycles", 64'(bcyc), 64'(exp_cyc));
                chk("bus_stable", 64'(stable), 64'd1);
            end

            if (bus.w_if_valid) begin
                if (fq.size() == 0) chk("unexpected_if_valid", 64'd1, 64'd0);
                else begin
                    exp_t e;
                    e = fq.pop_front();
                    chk("if_rdata", 64'(bus.w_if_rdata_32), 64'(e.rdata));
                    chk("if_err",   64'(bus.w_bus_err),     64'(e.err));
                    chk("if_stall_done", 64'(bus.w_if_stall), 64'd0);
                end
            end
            if (bus.w_mem_done) begin
                if (mq.size() == 0) chk("unexpected_mem_done", 64'd1, 64'd0);
                else begin
                    exp_t e;
                    e = mq.pop_front();
                    chk("mem_rdata", 64'(bus.w_mem_rdata_32), 64'(e.rdata));
                    chk("mem_err",   64'(bus.w_bus_err),      64'(e.err));
                    chk("mem_stall_done", 64'(bus.w_mem_stall), 64'd0);
                end
            end
            if (bus.w_bus_err && !bus.w_if_valid && !bus.w_mem_done)
                chk("stray_bus_err", 64'd1, 64'd0);
            prev_req = bus.w_bus_req;
        end
    end

    initial begin
        bus.w_if_req = 0;  bus.w_if_addr_32 = '0;
        bus.w_mem_req = 0; bus.w_mem_write = 0; bus.w_mem_addr_32 = '0;
        bus.w_mem_wdata_32 = '0; bus.w_mem_be_4 = '0;
        repeat (3) @(negedge clock);
        check_all_zero("rst");
        reset_n = 1'b1;

        // Single zero-wait fetch.
        fixed_wait = 0;
        step();
        issue_fetch(32'h0000_0040);
        #1 chk("if_stall_issue", 64'(bus.w_if_stall), 64'd1);
        wait_idle();

        // Simultaneous fetch and load: data first, then fetch.
        glog = "";
        step();
        issue_fetch(32'h0000_0044);
        issue_mem(1'b0, 32'h0000_0100, 32'h0, 4'hF);
        wait_idle();
        chk_s("simul_order", glog, "DF");

        // Store with three wait states.
        fixed_wait = 3;
        step();
        issue_mem(1'b1, 32'h0000_0200, 32'hDEAD_BEEF, 4'b0011);
        #1 chk("mem_stall_issue", 64'(bus.w_mem_stall), 64'd1);
        wait_idle();

        // Load never acked: timeout.
        fixed_wait = 100;
        step();
        issue_mem(1'b0, 32'h0000_0300, 32'h0, 4'hF);
        wait_idle();

        // Reset in the middle of a data access.
        step();
        issue_mem(1'b0, 32'h0000_0400, 32'h0, 4'hF);
        repeat (4) step();
        chk("rst_mid_busy", 64'(bus.w_bus_req), 64'd1);
        bus.w_mem_req = 1'b0;
        m_busy = 0;
        mq.delete();
        mem_last = '0;
        reset_n = 1'b0;
        #1 check_all_zero("rst_mid");
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        repeat (6) step();
        fixed_wait = 0;
        step();
        issue_mem(1'b0, 32'h0000_0500, 32'h0, 4'hF);
        wait_idle();

        // Starvation bound: both held continuously.
        begin
            int k = 0;
            glog = "";
            fixed_wait = 1;
            f_pct = 100; m_pct = 100;
            while (glog.len() < 6 && k < 300) begin step(); k++; end
            f_pct = 0; m_pct = 0;
            wait_idle();
            chk_s("starve_order", (glog.len() >= 6) ? glog.substr(0, 5) : glog, "DDDDFD");
        end

        // Randomised traffic with mixed wait states and timeouts.
        fixed_wait = -1;
        f_pct = 30; m_pct = 30;
        repeat (1500) step();
        f_pct = 0; m_pct = 0;
        wait_idle();
        repeat (4) step();
        chk("queues_empty", 64'(fq.size() + mq.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
